// File: rtl/qtree_sched_pkg.sv
// qtree_sched_pkg: shared state encoding, response record and statistics width
// for the quadtree lookup/update scheduler.
package qtree_sched_pkg;

  localparam int STAT_WIDTH     = 32;
  localparam int RSP_ADDR_WIDTH = 14;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    WRITE = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic                      match;
    logic [RSP_ADDR_WIDTH-1:0] addr;
  } qtree_rsp_t;

  function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] v);
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/qtree_sched_if.sv
// qtree_sched_if: client request/response, pipeline lookup/result, host update and
// stage-RAM write signals of the scheduler, named from the scheduler's point of view.
interface qtree_sched_if #(
  parameter int REQ_CNT        = 4,
  parameter int KEY_WIDTH      = 16,
  parameter int TAG_WIDTH      = $clog2(REQ_CNT),
  parameter int OUT_ADDR_WIDTH = 14,
  parameter int MM_ADDR_WIDTH  = 12,
  parameter int MM_DATA_WIDTH  = 32
);

  logic [REQ_CNT-1:0]           req_valid_i;
  logic [REQ_CNT*KEY_WIDTH-1:0] req_data_i;
  logic [REQ_CNT-1:0]           req_ready_o;

  logic                         pipe_valid_o;
  logic [KEY_WIDTH-1:0]         pipe_data_o;
  logic [TAG_WIDTH-1:0]         pipe_bypass_o;

  logic                         pipe_valid_i;
  logic                         pipe_match_i;
  logic [TAG_WIDTH-1:0]         pipe_bypass_i;
  logic [OUT_ADDR_WIDTH-1:0]    pipe_addr_i;

  logic [REQ_CNT-1:0]           rsp_valid_o;
  logic                         rsp_match_o;
  logic [OUT_ADDR_WIDTH-1:0]    rsp_addr_o;

  logic                         upd_valid_i;
  logic [MM_ADDR_WIDTH-1:0]     upd_addr_i;
  logic [MM_DATA_WIDTH-1:0]     upd_data_i;
  logic                         upd_ready_o;

  logic                         mm_ram_write_o;
  logic [MM_ADDR_WIDTH-1:0]     mm_ram_addr_o;
  logic [MM_DATA_WIDTH-1:0]     mm_ram_data_o;

  modport master (
    input  req_valid_i, req_data_i,
    input  pipe_valid_i, pipe_match_i, pipe_bypass_i, pipe_addr_i,
    input  upd_valid_i, upd_addr_i, upd_data_i,
    output req_ready_o,
    output pipe_valid_o, pipe_data_o, pipe_bypass_o,
    output rsp_valid_o, rsp_match_o, rsp_addr_o,
    output upd_ready_o,
    output mm_ram_write_o, mm_ram_addr_o, mm_ram_data_o
  );

  modport slave (
    output req_valid_i, req_data_i,
    output pipe_valid_i, pipe_match_i, pipe_bypass_i, pipe_addr_i,
    output upd_valid_i, upd_addr_i, upd_data_i,
    input  req_ready_o,
    input  pipe_valid_o, pipe_data_o, pipe_bypass_o,
    input  rsp_valid_o, rsp_match_o, rsp_addr_o,
    input  upd_ready_o,
    input  mm_ram_write_o, mm_ram_addr_o, mm_ram_data_o
  );

endinterface

// File: rtl/qtree_sched_rr_arb.sv
// qtree_rr_arb: combinational round-robin arbiter; searches from ptr_i+1 upward
// (wrapping) and returns a one-hot grant plus the winner's index.
module qtree_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic          en_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  int cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    if (en_i) begin
      for (int i = 1; i <= N; i++) begin
        cand = (int'(ptr_i) + i) % N;
        if (!valid_o && req_i[cand]) begin
          valid_o     = 1'b1;
          gnt_o[cand] = 1'b1;
          idx_o       = IW'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/qtree_sched.sv
// qtree_sched: round-robin lookup arbitration, result routing and drain-then-write update
// serialisation in front of the quadtree pipeline. Define QTREE_SCHED_STATS_EN for statistics.
module qtree_sched
  import qtree_sched_pkg::*;
#(
  parameter int REQ_CNT        = 4,
  parameter int KEY_WIDTH      = 16,
  parameter int TAG_WIDTH      = $clog2(REQ_CNT),
  parameter int OUT_ADDR_WIDTH = 14,
  parameter int MM_ADDR_WIDTH  = 12,
  parameter int MM_DATA_WIDTH  = 32,
  parameter int INFLIGHT_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  qtree_sched_if.master         bus,
  output logic                  err_o,
  output logic [STAT_WIDTH-1:0] stat_lookups_o,
  output logic [STAT_WIDTH-1:0] stat_updates_o
);

  localparam logic [INFLIGHT_WIDTH-1:0] INFLIGHT_LIMIT = '1;

  sched_state_t              state_q;
  logic [TAG_WIDTH-1:0]      ptr_q;
  logic [INFLIGHT_WIDTH-1:0] inflight_q;
  logic [INFLIGHT_WIDTH-1:0] inflight_d;
  logic                      slot_q;
  logic                      err_q;

  logic                      pipeValid_q;
  logic [KEY_WIDTH-1:0]      pipeData_q;
  logic [TAG_WIDTH-1:0]      pipeBypass_q;

  logic [REQ_CNT-1:0]        rspValid_q;
  qtree_rsp_t                rsp_q;

  logic                      updReady_q;
  logic                      mmWrite_q;
  logic [MM_ADDR_WIDTH-1:0]  mmAddr_q;
  logic [MM_DATA_WIDTH-1:0]  mmData_q;

  logic                      grantEn;
  logic                      grantValid;
  logic [REQ_CNT-1:0]        grantVec;
  logic [TAG_WIDTH-1:0]      grantIdx;
  logic                      tagOk;
  logic                      retire;

  // A waiting update blocks lookups, except in the single RUN cycle right after a write.
  assign grantEn = (state_q == RUN) && (inflight_q != INFLIGHT_LIMIT) &&
                   (!bus.upd_valid_i || slot_q);

  qtree_rr_arb #(
    .N  (REQ_CNT),
    .IW (TAG_WIDTH)
  ) u_arb (
    .req_i   (bus.req_valid_i),
    .en_i    (grantEn),
    .ptr_i   (ptr_q),
    .gnt_o   (grantVec),
    .idx_o   (grantIdx),
    .valid_o (grantValid)
  );

  assign bus.req_ready_o = rst_i ? grantVec : '0;
  assign tagOk           = int'(bus.pipe_bypass_i) < REQ_CNT;
  assign retire          = bus.pipe_valid_i && (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    if (grantValid && !retire) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!grantValid && retire) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= RUN;
      ptr_q        <= TAG_WIDTH'(REQ_CNT - 1);
      inflight_q   <= '0;
      slot_q       <= 1'b0;
      err_q        <= 1'b0;
      pipeValid_q  <= 1'b0;
      pipeData_q   <= '0;
      pipeBypass_q <= '0;
      rspValid_q   <= '0;
      rsp_q        <= '0;
      updReady_q   <= 1'b0;
      mmWrite_q    <= 1'b0;
      mmAddr_q     <= '0;
      mmData_q     <= '0;
    end else begin
      inflight_q  <= inflight_d;
      pipeValid_q <= grantValid;
      if (grantValid) begin
        pipeData_q   <= bus.req_data_i[grantIdx*KEY_WIDTH +: KEY_WIDTH];
        pipeBypass_q <= grantIdx;
        ptr_q        <= grantIdx;
      end

      // Results are always routed, even untracked ones; the anomaly only raises err.
      rspValid_q <= '0;
      if (bus.pipe_valid_i) begin
        rsp_q.match <= bus.pipe_match_i;
        rsp_q.addr  <= RSP_ADDR_WIDTH'(bus.pipe_addr_i);
        if (tagOk) begin
          rspValid_q[bus.pipe_bypass_i] <= 1'b1;
        end
        if ((inflight_q == '0) || !tagOk) begin
          err_q <= 1'b1;
        end
      end

      updReady_q <= 1'b0;
      mmWrite_q  <= 1'b0;
      case (state_q)
        RUN: begin
          slot_q <= 1'b0;
          if (bus.upd_valid_i && !grantValid) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (inflight_q == '0) begin
            state_q    <= WRITE;
            updReady_q <= 1'b1;
            mmWrite_q  <= 1'b1;
            mmAddr_q   <= bus.upd_addr_i;
            mmData_q   <= bus.upd_data_i;
          end
        end
        WRITE: begin
          slot_q  <= 1'b1;
          state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign bus.pipe_valid_o   = pipeValid_q;
  assign bus.pipe_data_o    = pipeData_q;
  assign bus.pipe_bypass_o  = pipeBypass_q;
  assign bus.rsp_valid_o    = rspValid_q;
  assign bus.rsp_match_o    = rsp_q.match;
  assign bus.rsp_addr_o     = OUT_ADDR_WIDTH'(rsp_q.addr);
  assign bus.upd_ready_o    = updReady_q;
  assign bus.mm_ram_write_o = mmWrite_q;
  assign bus.mm_ram_addr_o  = mmAddr_q;
  assign bus.mm_ram_data_o  = mmData_q;
  assign err_o              = err_q;

`ifdef QTREE_SCHED_STATS_EN
  logic [STAT_WIDTH-1:0] statLookups_q;
  logic [STAT_WIDTH-1:0] statUpdates_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      statLookups_q <= '0;
      statUpdates_q <= '0;
    end else begin
      if (grantValid) begin
        statLookups_q <= stat_inc(statLookups_q);
      end
      if (state_q == WRITE) begin
        statUpdates_q <= stat_inc(statUpdates_q);
      end
    end
  end

  assign stat_lookups_o = statLookups_q;
  assign stat_updates_o = statUpdates_q;
`else
  assign stat_lookups_o = '0;
  assign stat_updates_o = '0;
`endif

endmodule
